// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller: CSR addresses,
// interrupt codes, CSR bit positions and the request FSM state encoding.
package irq_ctrl_pkg;

  localparam int unsigned CoreXlen = 32;

  typedef enum logic [11:0] {
    CsrMstatus = 12'h300,
    CsrMie     = 12'h304,
    CsrMip     = 12'h344
  } csr_addr_e;

  typedef enum logic [3:0] {
    MSoftInt  = 4'd3,
    MTimerInt = 4'd7,
    MExtInt   = 4'd11
  } irq_code_e;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;
  localparam int unsigned MstatusMppLo   = 11;
  localparam int unsigned MstatusMppHi   = 12;

  // Shared by mie and mip.
  localparam int unsigned MsiBit = 3;
  localparam int unsigned MtiBit = 7;
  localparam int unsigned MeiBit = 11;

  typedef enum logic [1:0] {
    IrqIdle,
    IrqReq,
    IrqTaken
  } irq_state_e;

  // Fixed priority: external > software > timer.
  function automatic irq_code_e irq_pick(input logic ext, input logic sw);
    if (ext)     return MExtInt;
    else if (sw) return MSoftInt;
    else         return MTimerInt;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // NOTE: sequential state is always assigned with <= so every flop samples the pre-edge value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie and mip, and
// raises a prioritized interrupt trap request to the core via req/ack.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned Xlen = CoreXlen
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            irq_ext_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [Xlen-1:0] csr_wdata_i,
  output logic            csr_hit_o,
  output logic [Xlen-1:0] csr_rdata_o,
  input  logic            expt_i,
  input  logic            mret_i,
  output logic            irq_req_o,
  output logic [Xlen-1:0] irq_cause_o,
  input  logic            irq_ack_i,
  output logic            mstatus_mie_o
);

  logic       ext_sync;
  logic       mie_q, mpie_q;
  logic       meie_q, msie_q, mtie_q;
  irq_state_e state_q;
  logic [3:0] cause_q;
  logic       req_q;

  sync_2ff u_sync_ext (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (irq_ext_i),
    .q_o    (ext_sync)
  );

  logic ei_en, si_en, ti_en;
  logic candidate, latched_live, withdraw, ack_ok;

  assign ei_en     = ext_sync    & meie_q;
  assign si_en     = irq_sw_i    & msie_q;
  assign ti_en     = irq_timer_i & mtie_q;
  assign candidate = mie_q & (ei_en | si_en | ti_en);
  assign ack_ok    = (state_q == IrqReq) & req_q & irq_ack_i;

  // Withdrawal tracks only the source that was latched, not whichever is highest now.
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    latched_live = 1'b0;
    case (cause_q)
      MExtInt:   latched_live = ei_en;
      MSoftInt:  latched_live = si_en;
      MTimerInt: latched_live = ti_en;
      default:   latched_live = 1'b0;
    endcase
  end

  assign withdraw = ~(latched_live & mie_q);

  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = '0;
    case (csr_addr_i)
      CsrMstatus: begin
        csr_hit_o                               = 1'b1;
        csr_rdata_o[MstatusMieBit]              = mie_q;
        csr_rdata_o[MstatusMpieBit]             = mpie_q;
        csr_rdata_o[MstatusMppHi:MstatusMppLo]  = 2'b11;
      end
      CsrMie: begin
        csr_hit_o           = 1'b1;
        csr_rdata_o[MsiBit] = msie_q;
        csr_rdata_o[MtiBit] = mtie_q;
        csr_rdata_o[MeiBit] = meie_q;
      end
      CsrMip: begin
        csr_hit_o           = 1'b1;
        csr_rdata_o[MsiBit] = irq_sw_i;
        csr_rdata_o[MtiBit] = irq_timer_i;
        csr_rdata_o[MeiBit] = ext_sync;
      end
      default: ;
    endcase
  end

  // Same-cycle events are mutually exclusive; lower ones belong to squashed instructions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
      meie_q <= 1'b0;
      msie_q <= 1'b0;
      mtie_q <= 1'b0;
    end else if (expt_i || ack_ok) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (mret_i) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_we_i) begin
      case (csr_addr_i)
        CsrMstatus: begin
          mie_q  <= csr_wdata_i[MstatusMieBit];
          mpie_q <= csr_wdata_i[MstatusMpieBit];
        end
        CsrMie: begin
          msie_q <= csr_wdata_i[MsiBit];
          mtie_q <= csr_wdata_i[MtiBit];
          meie_q <= csr_wdata_i[MeiBit];
        end
        default: ;
      endcase
    end
  end

  // req_q rises one cycle after entering REQ and only while REQ is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IrqIdle;
      cause_q <= 4'd0;
      req_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IrqIdle: begin
          if (candidate && !expt_i) begin
            state_q <= IrqReq;
            cause_q <= irq_pick(ei_en, si_en);
          end
        end
        IrqReq: begin
          if (expt_i)        state_q <= IrqIdle;
          else if (ack_ok)   state_q <= IrqTaken;
          else if (withdraw) state_q <= IrqIdle;
          else               req_q   <= 1'b1;
        end
        IrqTaken: state_q <= IrqIdle;
        default:  state_q <= IrqIdle;
      endcase
    end
  end

  assign irq_req_o     = req_q;
  assign irq_cause_o   = {cause_q != 4'd0, {(Xlen-5){1'b0}}, cause_q};
  assign mstatus_mie_o = mie_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a scoreboard queue holds the expected cause of
// each interrupt request; a monitor pops it whenever irq_req_o rises.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_ext = 1'b0, irq_sw = 1'b0, irq_timer = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = 32'h0;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        expt = 1'b0, mret = 1'b0, irq_ack = 1'b0;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        mie_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic        req_prev = 1'b0;

  irq_ctrl #(.Xlen(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .irq_ext_i     (irq_ext),
    .irq_sw_i      (irq_sw),
    .irq_timer_i   (irq_timer),
    .csr_we_i      (csr_we),
    .csr_addr_i    (csr_addr),
    .csr_wdata_i   (csr_wdata),
    .csr_hit_o     (csr_hit),
    .csr_rdata_o   (csr_rdata),
    .expt_i        (expt),
    .mret_i        (mret),
    .irq_req_o     (irq_req),
    .irq_cause_o   (irq_cause),
    .irq_ack_i     (irq_ack),
    .mstatus_mie_o (mie_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp, input string name);
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic wait_req(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (irq_req) break;
      tick();
    end
    check(name, {31'b0, irq_req}, 32'h1);
  endtask

  // Monitor: every rising request must match the oldest expected cause.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && irq_req && !req_prev) begin
        if (exp_q.size() == 0) check("unexpected_req", {31'b0, irq_req}, 32'h0);
        else                   check("req_cause", irq_cause, exp_q.pop_front());
      end
      req_prev = irq_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_req", {31'b0, irq_req}, 32'h0);
    check("rst_cause", irq_cause, 32'h0);
    check("rst_mie_o", {31'b0, mie_o}, 32'h0);
    csr_read(12'h300, 32'h0000_1800, "rst_mstatus");
    csr_read(12'h304, 32'h0, "rst_mie");
    csr_read(12'h344, 32'h0, "rst_mip");

    // Timer interrupt: latency, ack, no re-request while MIE=0
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    check("mie_o_set", {31'b0, mie_o}, 32'h1);
    csr_read(12'h300, 32'h0000_1808, "mstatus_enabled");
    exp_q.push_back(32'h8000_0007);
    irq_timer = 1'b1;
    tick();
    check("timer_req_n1", {31'b0, irq_req}, 32'h0);
    tick();
    check("timer_req_n2", {31'b0, irq_req}, 32'h1);
    check("timer_cause", irq_cause, 32'h8000_0007);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("taken_req_low", {31'b0, irq_req}, 32'h0);
    check("taken_mie_o", {31'b0, mie_o}, 32'h0);
    csr_read(12'h300, 32'h0000_1880, "taken_mstatus");
    repeat (6) tick();
    check("no_rereq", {31'b0, irq_req}, 32'h0);

    // mret restores MIE; then ack and mret together: ack wins
    exp_q.push_back(32'h8000_0007);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    csr_read(12'h300, 32'h0000_1888, "mret_mstatus");
    wait_req(10, "timer_rereq_seen");
    irq_ack = 1'b1;
    mret    = 1'b1;
    tick();
    irq_ack = 1'b0;
    mret    = 1'b0;
    irq_timer = 1'b0;
    check("ack_mret_mie_o", {31'b0, mie_o}, 32'h0);
    csr_read(12'h300, 32'h0000_1880, "ack_beats_mret");

    // All three sources: external wins, then software after ext drops
    csr_write(12'h304, 32'h888);
    irq_ext = 1'b1;
    irq_sw = 1'b1;
    irq_timer = 1'b1;
    repeat (3) tick();
    csr_read(12'h344, 32'h0000_0888, "mip_all");
    exp_q.push_back(32'h8000_000B);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    wait_req(10, "ext_req_seen");
    check("ext_cause", irq_cause, 32'h8000_000B);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_ext = 1'b0;
    repeat (4) tick();
    exp_q.push_back(32'h8000_0003);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    wait_req(10, "sw_req_seen");
    check("sw_cause", irq_cause, 32'h8000_0003);

    // Clearing MIE in REQ withdraws the request without a trap save
    csr_write(12'h300, 32'h0);
    check("req_held_at_write", {31'b0, irq_req}, 32'h1);
    tick();
    check("withdraw_mie_clear", {31'b0, irq_req}, 32'h0);
    csr_read(12'h300, 32'h0000_1800, "withdraw_mstatus");

    // expt and ack together in REQ: exception wins
    csr_write(12'h300, 32'h8);
    exp_q.push_back(32'h8000_0003);
    wait_req(10, "sw_req2_seen");
    expt    = 1'b1;
    irq_ack = 1'b1;
    tick();
    expt    = 1'b0;
    irq_ack = 1'b0;
    irq_sw = 1'b0;
    irq_timer = 1'b0;
    check("expt_req_low", {31'b0, irq_req}, 32'h0);
    csr_read(12'h300, 32'h0000_1880, "expt_ack_mstatus");
    repeat (3) tick();
    check("expt_idle", {31'b0, irq_req}, 32'h0);

    // mret with MPIE=1, MIE=0; ack outside REQ is ignored
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_mie_o", {31'b0, mie_o}, 32'h1);
    csr_read(12'h300, 32'h0000_1888, "mret_mstatus2");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    csr_read(12'h300, 32'h0000_1888, "ack_outside_req");

    // Write masking, read-only mip, address decode
    csr_write(12'h304, 32'h0);
    csr_read(12'h304, 32'h0, "mie_cleared");
    irq_sw = 1'b1;
    tick();
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read(12'h344, 32'h0000_0008, "mip_readonly");
    irq_sw = 1'b0;
    tick();
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read(12'h304, 32'h0000_0888, "mie_mask");
    check("hit_mie", {31'b0, csr_hit}, 32'h1);
    csr_read(12'h300, 32'h0000_1888, "mstatus_mpp");
    csr_read(12'h305, 32'h0, "miss_rdata");
    check("miss_hit", {31'b0, csr_hit}, 32'h0);

    // Asynchronous reset in the middle of a request
    exp_q.push_back(32'h8000_0007);
    irq_timer = 1'b1;
    wait_req(10, "pre_reset_req_seen");
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, irq_req}, 32'h0);
    check("async_rst_cause", irq_cause, 32'h0);
    check("async_rst_mie_o", {31'b0, mie_o}, 32'h0);
    irq_timer = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    csr_read(12'h300, 32'h0000_1800, "post_rst_mstatus");
    csr_read(12'h304, 32'h0, "post_rst_mie");
    tick();
    check("post_rst_req", {31'b0, irq_req}, 32'h0);

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
